// File: rtl/jt900h_ramctl.sv
// Bridge from the jt900h CPU bus to a req/ack word memory, with a one-word read
// buffer and a write-done latch so a held write strobe issues only one memory write.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | evaluate CPU bus; start a read miss or a new write
// RD    | read request outstanding, waiting for mem_ack
// WR    | write request outstanding, waiting for mem_ack
// DONE  | one-cycle write completion, cpu_rdy asserted
module jt900h_ramctl #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    cpu_we,
    output logic [15:0]   cpu_din,
    output logic          cpu_rdy,
    output logic [AW-2:0] mem_addr,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_be,
    input  logic          mem_ack
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-2:0] tag_q, tag_d;
    logic          valid_q, valid_d;
    logic [15:0]   buf_q, buf_d;
    logic          wdone_q, wdone_d;
    logic [AW-2:0] wtag_q, wtag_d;
    logic [AW-2:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_din_q, mem_din_d;
    logic [1:0]    mem_be_q, mem_be_d;
    logic          mem_wr_q, mem_wr_d;
    logic          mem_req_q, mem_req_d;

    logic [AW-2:0] wa;
    logic          is_write;
    logic          rd_hit;
    logic          wr_hit;
    logic          unused_addr_lsb;

    assign wa              = cpu_addr[AW-1:1];
    assign unused_addr_lsb = cpu_addr[0];
    assign is_write        = (cpu_we != 2'b00);
    assign rd_hit          = valid_q && (tag_q == wa);
    assign wr_hit          = wdone_q && (wtag_q == wa);

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        buf_d      = buf_q;
        wdone_d    = wdone_q;
        wtag_d     = wtag_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        mem_wr_d   = mem_wr_q;
        mem_req_d  = mem_req_q;

        // Any break in the write strobe or a move to another word re-arms writes.
        if (!is_write || (wa != wtag_q)) begin
            wdone_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cen) begin
                    if (is_write) begin
                        if (!wr_hit) begin
                            mem_addr_d = wa;
                            mem_din_d  = cpu_dout;
                            mem_be_d   = cpu_we;
                            mem_wr_d   = 1'b1;
                            mem_req_d  = 1'b1;
                            state_d    = WR;
                        end
                    end else if (!rd_hit) begin
                        mem_addr_d = wa;
                        mem_be_d   = 2'b11;
                        mem_wr_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    buf_d     = mem_dout;
                    tag_d     = mem_addr_q;
                    valid_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    wdone_d   = 1'b1;
                    wtag_d    = mem_addr_q;
                    // Keep the buffered copy coherent; non-buffered words are not allocated.
                    if (valid_q && (tag_q == mem_addr_q)) begin
                        if (mem_be_q[1]) buf_d[15:8] = mem_din_q[15:8];
                        if (mem_be_q[0]) buf_d[7:0]  = mem_din_q[7:0];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            buf_q      <= '0;
            wdone_q    <= 1'b0;
            wtag_q     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            mem_wr_q   <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            buf_q      <= buf_d;
            wdone_q    <= wdone_d;
            wtag_q     <= wtag_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            mem_wr_q   <= mem_wr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign cpu_din  = buf_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_be   = mem_be_q;
    assign mem_wr   = mem_wr_q;
    assign mem_req  = mem_req_q;
    assign cpu_rdy  = (state_q == DONE) ||
                      ((state_q == IDLE) && ((is_write && wr_hit) || (!is_write && rd_hit)));

endmodule

// File: tb/tb_jt900h_ramctl.sv
// Randomized bench for jt900h_ramctl: a word-memory model answers requests with
// random latency, and CPU-level accesses are checked against buffer/memory contents.
module tb_jt900h_ramctl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  cpu_we = '0;
    logic [15:0] cpu_din;
    logic        cpu_rdy;
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_be;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    jt900h_ramctl #(.AW(24)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: untouched words read as an address-derived pattern.
    logic [15:0] mem_m [logic [22:0]];

    function automatic logic [15:0] mem_read(input logic [22:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Reference view of the bridge: one buffered word and the last completed write.
    bit          exp_valid = 0;
    logic [22:0] exp_tag = '0;
    bit          exp_wdone = 0;
    logic [22:0] exp_wtag = '0;

    logic [41:0] exp_fields = '0;
    int          req_count = 0;
    int          force_lat = 0;
    int          last_wait = 0;

    // Memory responder
    initial begin : responder
        bit          busy;
        int          remaining;
        logic [41:0] cap;
        logic [15:0] rdata;
        logic [15:0] wv;
        busy = 0;
        remaining = 0;
        cap = '0;
        rdata = '0;
        mem_ack = 1'b0;
        mem_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                busy = 0;
                mem_ack = 1'b0;
                continue;
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy = 0;
                check("ack_edge_rdy", 64'(cpu_rdy), 64'(1));
                if (!cap[41]) check("ack_edge_rdata", 64'(cpu_din), 64'(rdata));
                continue;
            end
            if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    req_count++;
                    cap = {mem_wr, mem_be, mem_addr, mem_din};
                    if (exp_fields[41])
                        check("req_fields", 64'(cap), 64'(exp_fields));
                    else
                        check("req_fields", 64'(cap[41:16]), 64'(exp_fields[41:16]));
                    remaining = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
                end
                remaining--;
                if (remaining == 0) begin
                    check("req_stable", 64'({mem_wr, mem_be, mem_addr, mem_din}), 64'(cap));
                    if (mem_wr) begin
                        wv = mem_read(mem_addr);
                        if (mem_be[1]) wv[15:8] = mem_din[15:8];
                        if (mem_be[0]) wv[7:0] = mem_din[7:0];
                        mem_m[mem_addr] = wv;
                        mem_dout = 16'($urandom);
                    end else begin
                        rdata = mem_read(mem_addr);
                        mem_dout = rdata;
                    end
                    mem_ack = 1'b1;
                end
            end
        end
    end

    task automatic wait_rdy(input bit rand_cen, output bit got);
        got = 0;
        last_wait = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (cpu_rdy) begin
                got = 1;
                break;
            end
            @(negedge clk);
            last_wait++;
            if (rand_cen) cen = ($urandom_range(0, 3) != 0);
        end
        check("rdy_timeout", 64'(got), 64'(1));
    endtask

    task automatic do_access(input logic [23:0] addr, input logic [1:0] we,
                             input logic [15:0] d, input int hold, input bit rand_cen);
        logic [22:0] wa;
        int          req0;
        bit          hit;
        bit          got;
        bit          held_ok;
        wa = addr[23:1];
        @(negedge clk);
        cpu_addr = addr;
        cpu_we = we;
        cpu_dout = d;
        cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
        exp_fields = {(we != 2'b00), (we != 2'b00) ? we : 2'b11, wa, d};
        hit = (we == 2'b00) ? (exp_valid && exp_tag == wa) : (exp_wdone && exp_wtag == wa);
        if (!hit) exp_wdone = 0;
        req0 = req_count;
        wait_rdy(rand_cen, got);
        if (hit) check("hit_immediate", 64'(last_wait), 64'(0));
        check("mem_reqs", 64'(req_count - req0), hit ? 64'(0) : 64'(1));
        if (we == 2'b00) begin
            check("rd_data", 64'(cpu_din), 64'(mem_read(wa)));
            exp_valid = 1;
            exp_tag = wa;
        end else begin
            exp_wdone = 1;
            exp_wtag = wa;
            held_ok = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                cen = ($urandom_range(0, 1) != 0);
                #1;
                if (!cpu_rdy) held_ok = 0;
            end
            check("wr_hold_rdy", 64'(held_ok), 64'(1));
            check("wr_single_req", 64'(req_count - req0), hit ? 64'(0) : 64'(1));
        end
    endtask

    initial begin : main
        logic [22:0] pool [6];
        bit          ok;
        bit          got;
        int          req0;
        logic [1:0]  we;
        pool[0] = 23'h000000;
        pool[1] = 23'h7FFFFF;
        pool[2] = 23'h000080;
        pool[3] = 23'h000081;
        pool[4] = 23'h400000;
        pool[5] = 23'h2AAAAA;

        // Reset held with random bus activity
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cen = 1'($urandom);
            cpu_addr = 24'($urandom);
            cpu_we = 2'($urandom);
            cpu_dout = 16'($urandom);
            #1;
            if (i >= 1 && ({cpu_din, cpu_rdy, mem_addr, mem_din, mem_req, mem_wr, mem_be} != '0))
                ok = 0;
        end
        check("reset_outputs_zero", 64'(ok), 64'(1));
        check("reset_rdy", 64'(cpu_rdy), 64'(0));
        check("reset_req", 64'(mem_req), 64'(0));
        @(negedge clk);
        cen = 1'b0;
        cpu_we = 2'b00;
        rst = 1'b1;

        // Read miss, then hit on the other byte of the same word
        force_lat = 3;
        mem_m[23'h000080] = 16'hBEEF;
        do_access(24'h000100, 2'b00, 16'h0000, 0, 0);
        check("miss_latency", 64'(last_wait), 64'(4));
        check("miss_data", 64'(cpu_din), 64'(16'hBEEF));
        do_access(24'h000101, 2'b00, 16'h0000, 0, 0);

        // Write hit with merge, strobe held for 10 cycles
        do_access(24'h000100, 2'b10, 16'h1234, 10, 0);
        check("wr_latency", 64'(last_wait), 64'(4));
        check("merge_data", 64'(cpu_din), 64'(16'h12EF));
        check("mem_after_write", 64'(mem_read(23'h000080)), 64'(16'h12EF));
        force_lat = 0;

        // cen low with a miss pending
        @(negedge clk);
        cen = 1'b0;
        cpu_we = 2'b00;
        cpu_addr = 24'h000300;
        exp_fields = {1'b0, 2'b11, 23'h000180, 16'h0000};
        exp_wdone = 0;
        req0 = req_count;
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req) ok = 0;
        end
        check("cen0_no_req", 64'(ok), 64'(1));
        check("cen0_no_count", 64'(req_count - req0), 64'(0));
        cen = 1'b1;
        @(posedge clk);
        #1;
        check("cen1_req_starts", 64'(mem_req), 64'(1));
        @(negedge clk);
        wait_rdy(0, got);
        check("cen_rd_data", 64'(cpu_din), 64'(mem_read(23'h000180)));
        exp_valid = 1;
        exp_tag = 23'h000180;

        // Reset during an outstanding read
        force_lat = 10;
        @(negedge clk);
        cpu_addr = 24'h000400;
        cpu_we = 2'b00;
        cen = 1'b1;
        exp_fields = {1'b0, 2'b11, 23'h000200, 16'h0000};
        @(posedge clk);
        #1;
        check("rst_mid_req_up", 64'(mem_req), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b0;
        #1;
        check("rst_mid_req_drop", 64'(mem_req), 64'(0));
        exp_valid = 0;
        exp_wdone = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        force_lat = 0;
        do_access(24'h000400, 2'b00, 16'h0000, 0, 0);
        do_access(24'h000300, 2'b00, 16'h0000, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            we = ($urandom_range(0, 99) < 45) ? 2'b00 : 2'($urandom_range(1, 3));
            do_access({pool[$urandom_range(0, 5)], 1'($urandom)}, we, 16'($urandom),
                      $urandom_range(0, 3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
